// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit between the core datapath and a valid/ready data memory port
//   clk, reset                      clock, async active-high reset
//   req_valid/req_ready             core request handshake (req_ready = idle)
//   req_we/req_funct3/req_addr/req_wdata  request fields, store data LSB-aligned
//   mem_valid/mem_ready             memory request handshake
//   mem_we/mem_addr/mem_wdata/mem_wstrb   word-aligned request, lane-shifted data and strobes
//   mem_rdata/mem_rvalid            read response from memory
//   rsp_valid/rsp_rdata/rsp_err     one-cycle completion pulse, extended load data, status
module riscv_lsu #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [XLEN-1:0]      req_wdata,
    output logic                 mem_valid,
    input  logic                 mem_ready,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [XLEN-1:0]      mem_wdata,
    output logic [XLEN/8-1:0]    mem_wstrb,
    input  logic [XLEN-1:0]      mem_rdata,
    input  logic                 mem_rvalid,
    output logic                 rsp_valid,
    output logic [XLEN-1:0]      rsp_rdata,
    output logic [1:0]           rsp_err
);
    localparam int STRB_W = XLEN / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_REQ    = 2'd1;
    localparam logic [1:0] S_WAIT_R = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic [31:0]       cnt_q, cnt_d;
    logic              mem_valid_q, mem_valid_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]        rsp_err_q, rsp_err_d;

    logic              accept, legal, misaligned, timeout_hit;
    logic [OFF_W-1:0]  req_off, size_mask;
    logic [7:0]        strb_base;
    logic [6:0]        ext_sh;
    logic [XLEN-1:0]   rd_shift, rd_left, rd_ext;
    logic signed [XLEN-1:0] rd_sext;

    assign req_ready = (state_q == S_IDLE);
    assign accept    = req_valid && req_ready;
    assign req_off   = req_addr[OFF_W-1:0];

    always_comb begin
        legal = req_we ? (req_funct3 inside {3'b000, 3'b001, 3'b010} || (XLEN == 64 && req_funct3 == 3'b011))
                       : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101} ||
                          (XLEN == 64 && req_funct3 inside {3'b011, 3'b110}));
        size_mask  = OFF_W'((4'd1 << req_funct3[1:0]) - 4'd1);
        misaligned = |(req_off & size_mask);
        strb_base  = 8'((16'd1 << (5'd1 << req_funct3[1:0])) - 16'd1);
        // Left-justify the selected bytes, then shift back down so the top byte's
        // MSB becomes the sign for the arithmetic shift.
        ext_sh   = 7'(XLEN) - (7'd8 << funct3_q[1:0]);
        rd_shift = mem_rdata >> {off_q, 3'b000};
        rd_left  = rd_shift << ext_sh;
        rd_sext  = $signed(rd_left) >>> ext_sh;
        rd_ext   = funct3_q[2] ? (rd_left >> ext_sh) : rd_sext;
        timeout_hit = (TIMEOUT > 0) && (cnt_q == 32'(TIMEOUT - 1));
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        cnt_d       = 32'd0;
        rsp_rdata_d = '0;
        rsp_err_d   = 2'b00;
        case (state_q)
            S_IDLE: if (accept) begin
                we_d     = req_we;
                funct3_d = req_funct3;
                off_d    = req_off;
                addr_d   = {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                wdata_d  = req_wdata << {req_off, 3'b000};
                wstrb_d  = STRB_W'(strb_base) << req_off;
                state_d  = (!legal || misaligned) ? S_RESP : S_REQ;
                rsp_err_d = !legal ? 2'b10 : misaligned ? 2'b01 : 2'b00;
            end
            S_REQ: begin
                cnt_d = cnt_q + 32'd1;
                if (mem_ready) state_d = we_q ? S_RESP : S_WAIT_R;
                else if (timeout_hit) begin
                    state_d   = S_RESP;
                    rsp_err_d = 2'b11;
                end
            end
            S_WAIT_R: begin
                cnt_d = cnt_q + 32'd1;
                if (mem_rvalid) begin
                    state_d     = S_RESP;
                    rsp_rdata_d = rd_ext;
                end else if (timeout_hit) begin
                    state_d   = S_RESP;
                    rsp_err_d = 2'b11;
                end
            end
            default: state_d = S_IDLE;
        endcase
        mem_valid_d = (state_d == S_REQ);
        rsp_valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            off_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            cnt_q       <= 32'd0;
            mem_valid_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 2'b00;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            cnt_q       <= cnt_d;
            mem_valid_q <= mem_valid_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign mem_valid = mem_valid_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
endmodule
